// File: rtl/lock_code_sequencer_if.sv
// Signal bundle between the code-entry sequencer and whatever drives or observes it.
// The master side issues commands and lock responses; the slave side is the sequencer itself.
interface lock_code_sequencer_if;
  logic       start;
  logic       abort;
  logic [7:0] code;
  logic       locked;
  logic       alarm;
  logic [7:0] sw;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fail;
  logic [2:0] step_idx;
  logic [2:0] state;

  modport master (
    output start, abort, code, locked, alarm,
    input  sw, busy, done, pass, fail, step_idx, state
  );

  modport slave (
    input  start, abort, code, locked, alarm,
    output sw, busy, done, pass, fail, step_idx, state
  );
endinterface

// File: rtl/lock_code_sequencer.sv
// Presents a latched 8-bit combination on the lock switches one index per timed step,
// then waits for the lock to open and reports pass/fail.
module lock_code_sequencer #(
  parameter int STEP_CYCLES = 4,
  parameter int RESP_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  clear,
  lock_code_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       step_q, step_d;
  logic [7:0]       sw_q, sw_d;
  logic [7:0]       code_q, code_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;
  logic [2:0]       step_nxt;

  assign step_nxt = step_q + 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    sw_d    = sw_q;
    code_d  = code_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          code_d  = bus.code;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          sw_d    = {7'd0, bus.code[0]};
          step_d  = 3'd0;
          cnt_d   = '0;
          state_d = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        if (bus.alarm || bus.abort) begin
          state_d = ST_RELEASE;
          sw_d    = 8'd0;
          step_d  = 3'd0;
          cnt_d   = '0;
          fail_d  = 1'b1;
        end else if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          if (step_q == 3'd7) begin
            state_d = ST_WAIT;
            step_d  = 3'd0;
          end else begin
            // Lower bits already hold their code values; only the new index is loaded.
            step_d           = step_nxt;
            sw_d[step_nxt]   = code_q[step_nxt];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT: begin
        // Alarm/abort outrank an unlock seen in the same cycle.
        if (bus.alarm || bus.abort) begin
          state_d = ST_RELEASE;
          sw_d    = 8'd0;
          cnt_d   = '0;
          fail_d  = 1'b1;
        end else if (!bus.locked) begin
          state_d = ST_RELEASE;
          sw_d    = 8'd0;
          cnt_d   = '0;
          pass_d  = 1'b1;
        end else if (cnt_q == RESP_LAST) begin
          state_d = ST_RELEASE;
          sw_d    = 8'd0;
          cnt_d   = '0;
          fail_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        sw_d    = 8'd0;
        step_d  = 3'd0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= 3'd0;
      sw_q    <= 8'd0;
      code_q  <= 8'd0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      sw_q    <= sw_d;
      code_q  <= code_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
    end
  end

  assign bus.sw       = sw_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.fail     = fail_q;
  assign bus.step_idx = step_q;
  assign bus.state    = state_q;

endmodule
